prelude_regfile_wb: RTL

//  Register file and writeback stage of the Prelude 8-bit datapath. Two combinational read

---
 rtl/prelude_pkg.sv | 15 +
 rtl/prelude_wb_fifo.sv | 68 ++++++
 rtl/prelude_regfile_wb.sv | 96 +++++++++
 3 files changed

// File: rtl/prelude_pkg.sv
// Shared widths and types for the Prelude register file and writeback queue.
package prelude_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    word_t             data;
  } wb_entry_t;

endpackage

// File: rtl/prelude_wb_fifo.sv
// Two-entry in-order queue of pending ALU writes; a load kills every entry aimed at its
// address and the survivors are compacted towards the head without reordering.
module prelude_wb_fifo
  import prelude_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  output wb_entry_t [1:0]   entry_o,
  output logic [1:0]        valid_o,
  output logic [1:0]        count_o,
  output logic              full_o
);

  wb_entry_t [1:0] entry_q, entry_d;
  logic [1:0]      valid_q, valid_d;
  logic [1:0]      kill;
  logic            keep0, keep1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      kill[i] = kill_i && valid_q[i] && (entry_q[i].addr == kill_addr_i);
    end
    keep0   = valid_q[0] && !kill[0] && !pop_i;
    keep1   = valid_q[1] && !kill[1];
    entry_d = entry_q;
    valid_d = 2'b00;
    if (keep0) begin
      valid_d[0] = 1'b1;
      if (keep1) begin
        valid_d[1] = 1'b1;
      end
    end else if (keep1) begin
      entry_d[0] = entry_q[1];
      valid_d[0] = 1'b1;
    end
    // Push lands after the kill/pop compaction; caller only pushes when not full.
    if (push_i) begin
      if (!valid_d[0]) begin
        entry_d[0] = push_entry_i;
        valid_d[0] = 1'b1;
      end else begin
        entry_d[1] = push_entry_i;
        valid_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
      valid_q <= 2'b00;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;
  assign count_o = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};
  assign full_o  = &valid_q;

endmodule

// File: rtl/prelude_regfile_wb.sv
// Prelude register file with writeback queue, load-priority commit and hazard reporting.
// Build with PRELUDE_RF_FWD_EN defined to bypass pending writes onto the read ports.
module prelude_regfile_wb #(
  parameter int unsigned DATA_W   = prelude_pkg::DATA_W,
  parameter int unsigned NUM_REGS = prelude_pkg::NUM_REGS,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              hazard_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              hazard_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [1:0]        wb_pending
);

  import prelude_pkg::*;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  wb_entry_t [1:0]   entry;
  logic [1:0]        entry_valid;
  logic              full, push, pop;
  logic [1:0]        match_a, match_b;
  logic              ld_hit_a, ld_hit_b;

  // Ready depends on registered occupancy only, so a full queue never refills on a pop.
  assign wb_ready = !rst && !full;
  assign push     = wb_valid && wb_ready;
  assign pop      = !ld_valid && entry_valid[0];

  prelude_wb_fifo u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_entry_i ('{addr: wb_addr, data: wb_data}),
    .pop_i        (pop),
    .kill_i       (ld_valid),
    .kill_addr_i  (ld_addr),
    .entry_o      (entry),
    .valid_o      (entry_valid),
    .count_o      (wb_pending),
    .full_o       (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (ld_valid) begin
      regs_q[ld_addr] <= ld_data;
    end else if (pop) begin
      regs_q[entry[0].addr] <= entry[0].data;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      match_a[i] = entry_valid[i] && (entry[i].addr == rd_addr_a);
      match_b[i] = entry_valid[i] && (entry[i].addr == rd_addr_b);
    end
    ld_hit_a = ld_valid && (ld_addr == rd_addr_a);
    ld_hit_b = ld_valid && (ld_addr == rd_addr_b);
  end

`ifdef PRELUDE_RF_FWD_EN
  // Later assignments win: array < older entry < newer entry < load.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (match_a[0]) rd_data_a = entry[0].data;
    if (match_a[1]) rd_data_a = entry[1].data;
    if (ld_hit_a)   rd_data_a = ld_data;
    rd_data_b = regs_q[rd_addr_b];
    if (match_b[0]) rd_data_b = entry[0].data;
    if (match_b[1]) rd_data_b = entry[1].data;
    if (ld_hit_b)   rd_data_b = ld_data;
  end
  assign hazard_a = 1'b0;
  assign hazard_b = 1'b0;
`else
  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign hazard_a  = (|match_a) || ld_hit_a;
  assign hazard_b  = (|match_b) || ld_hit_b;
`endif

endmodule
